// File: rtl/data_types_pkg.sv
// Shared types for the operand load controller: FSM state encoding and the
// operand data width. `WIDTH is the shared data-width definition; it can be
// overridden on the command line, otherwise it defaults to 16.
`ifndef WIDTH
`define WIDTH 16
`endif

package data_types_pkg;

  localparam int DATA_W = `WIDTH;
  localparam int IDX_W  = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_A  = 3'd1,
    LOAD_B  = 3'd2,
    COMPUTE = 3'd3,
    RESULT  = 3'd4
  } olc_state_e;

endpackage

// File: rtl/operand_load_controller_index.sv
// matrix_index_counter: row-major (column-fastest) element index generator.
// One instance serves both operands: trans=0 walks ROWS x COLS (operand A),
// trans=1 walks COLS x ROWS (operand B). last flags the final element of the
// currently selected shape; advancing past it wraps to (0,0).
import data_types_pkg::*;

module matrix_index_counter #(
  parameter int ROWS = 4,
  parameter int COLS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             adv,
  input  logic             trans,
  output logic [IDX_W-1:0] row,
  output logic [IDX_W-1:0] col,
  output logic             last
);

  logic [IDX_W-1:0] row_max, col_max;
  logic             col_end;

  assign row_max = trans ? IDX_W'(COLS - 1) : IDX_W'(ROWS - 1);
  assign col_max = trans ? IDX_W'(ROWS - 1) : IDX_W'(COLS - 1);
  assign col_end = (col == col_max);
  assign last    = col_end && (row == row_max);

  // Column advances every accepted element; row advances when the column wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (adv) begin
      if (col_end) begin
        col <= '0;
        row <= (row == row_max) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/operand_load_controller.sv
// operand_load_controller: streams operand A (N_ROWS x N_COLUMNS) then
// operand B (N_COLUMNS x N_ROWS) into matrix buffers, kicks the compute
// engine, and holds the result handshake until it is consumed.
// Optional feature macro: LOAD_TIMEOUT_EN enables a compute watchdog that
// raises a sticky error and returns to IDLE after TIMEOUT_CYCLES.
import data_types_pkg::*;

module operand_load_controller #(
  parameter int N_ROWS         = 4,
  parameter int N_COLUMNS      = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              a_we,
  output logic              b_we,
  output logic [IDX_W-1:0]  wr_row,
  output logic [IDX_W-1:0]  wr_col,
  output logic [DATA_W-1:0] wr_data,
  output logic              comp_start,
  input  logic              comp_done,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              busy,
  output logic              error
);

  olc_state_e state, state_nxt;
  logic       accept, idx_last, idx_clr, start_acc, timeout;

  // Abort cancels any beat in flight, so it also gates acceptance.
  assign accept    = in_valid && in_ready && !abort;
  assign start_acc = (state == IDLE) && start && !abort;
  assign idx_clr   = abort || ((state != LOAD_A) && (state != LOAD_B));

  matrix_index_counter #(
    .ROWS (N_ROWS),
    .COLS (N_COLUMNS)
  ) u_idx (
    .clk   (clk),
    .rst   (rst),
    .clr   (idx_clr),
    .adv   (accept),
    .trans (state == LOAD_B),
    .row   (wr_row),
    .col   (wr_col),
    .last  (idx_last)
  );

`ifdef LOAD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;

  assign timeout = (state == COMPUTE) && !comp_done && (tcnt == TW'(TIMEOUT_CYCLES - 1));

  // Watchdog counts cycles spent in COMPUTE; restarts from zero on every entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                              tcnt <= '0;
    else if ((state == COMPUTE) && !abort) tcnt <= tcnt + 1'b1;
    else                                   tcnt <= '0;
  end

  // Sticky error: set on watchdog expiry, cleared only by the next accepted start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   error <= 1'b0;
    else if (start_acc)         error <= 1'b0;
    else if (timeout && !abort) error <= 1'b1;
  end
`else
  assign timeout = 1'b0;
  assign error   = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; abort overrides everything else.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)               state_nxt = LOAD_A;
      LOAD_A:  if (accept && idx_last)  state_nxt = LOAD_B;
      LOAD_B:  if (accept && idx_last)  state_nxt = COMPUTE;
      COMPUTE: if (comp_done)           state_nxt = RESULT;
               else if (timeout)        state_nxt = IDLE;
      RESULT:  if (res_ready)           state_nxt = IDLE;
      default:                          state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  // Registered one-cycle kick on entry to COMPUTE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) comp_start <= 1'b0;
    else      comp_start <= (state != COMPUTE) && (state_nxt == COMPUTE);
  end

  // Output decode; write strobes are combinational on the accepted beat.
  always_comb begin
    in_ready  = (state == LOAD_A) || (state == LOAD_B);
    a_we      = accept && (state == LOAD_A);
    b_we      = accept && (state == LOAD_B);
    wr_data   = accept ? in_data : '0;
    res_valid = (state == RESULT);
    busy      = (state != IDLE);
  end

endmodule

// File: tb/tb_operand_load_controller.sv
// Directed bench for operand_load_controller with a write-strobe scoreboard.
// Build with LOAD_TIMEOUT_EN defined to exercise the compute watchdog.
module tb_operand_load_controller;

  localparam int NR = 4;
  localparam int NC = 2;
  localparam int W  = `WIDTH;

  logic         clk = 1'b0;
  logic         rst, start, abort, in_valid, comp_done, res_ready;
  logic [W-1:0] in_data;
  logic         in_ready, a_we, b_we, comp_start, res_valid, busy, error;
  logic [3:0]   wr_row, wr_col;
  logic [W-1:0] wr_data;

  typedef struct {
    logic       is_b;
    logic [3:0] row;
    logic [3:0] col;
    logic [W-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;

  operand_load_controller #(
    .N_ROWS(NR), .N_COLUMNS(NC), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .a_we(a_we), .b_we(b_we), .wr_row(wr_row), .wr_col(wr_col),
    .wr_data(wr_data), .comp_start(comp_start), .comp_done(comp_done),
    .res_valid(res_valid), .res_ready(res_ready), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Every strobe seen must match the oldest expected write.
  always @(negedge clk) begin
    if (a_we || b_we) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_strobe obs=a%0b/b%0b exp=none", a_we, b_we);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("we_sel", 32'({a_we, b_we}), e.is_b ? 32'h1 : 32'h2);
        chk("wr_addr", 32'({wr_row, wr_col}), 32'({e.row, e.col}));
        chk("wr_data", 32'(wr_data), 32'(e.data));
      end
    end
  end

  task automatic push_beat(input int i, input logic [W-1:0] d);
    exp_t x;
    if (i < NR * NC) begin
      x.is_b = 1'b0; x.row = 4'(i / NC); x.col = 4'(i % NC);
    end else begin
      x.is_b = 1'b1; x.row = 4'((i - NR * NC) / NR); x.col = 4'((i - NR * NC) % NR);
    end
    x.data = d;
    exp_q.push_back(x);
  endtask

  // Start a job and stream n beats (data base..base+n-1), optional idle gaps.
  task automatic load_beats(input int base, input int n, input bit gaps);
    start = 1'b1; cyc(); start = 1'b0;
    chk("in_ready_load", 32'(in_ready), 32'd1);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        in_valid = 1'b0; in_data = '1; cyc();
      end
      in_valid = 1'b1; in_data = W'(base + i);
      push_beat(i, W'(base + i));
      cyc();
    end
    in_valid = 1'b0; in_data = '0;
  endtask

  task automatic finish_job();
    comp_done = 1'b1; cyc(); comp_done = 1'b0;
    chk("res_valid_enter", 32'(res_valid), 32'd1);
    res_ready = 1'b1; cyc(); res_ready = 1'b0;
    chk("busy_after_job", 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    comp_done = 1'b0; res_ready = 1'b0; in_data = '0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_comp_start", 32'(comp_start), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    cyc();
    chk("rel_in_ready", 32'(in_ready), 32'd0);
    chk("rel_we", 32'({a_we, b_we}), 32'd0);
    chk("rel_busy", 32'(busy), 32'd0);

    // comp_done outside COMPUTE is ignored
    comp_done = 1'b1; cyc(); comp_done = 1'b0;
    chk("done_idle_ignored", 32'(busy), 32'd0);

    // Job 1: back-to-back beats 1..16
    load_beats(1, 2 * NR * NC, 1'b0);
    chk("comp_start_pulse", 32'(comp_start), 32'd1);
    chk("compute_busy", 32'(busy), 32'd1);
    chk("compute_in_ready", 32'(in_ready), 32'd0);
    start = 1'b1; cyc(); start = 1'b0;
    chk("comp_start_one_cycle", 32'(comp_start), 32'd0);
    chk("start_ignored_compute", 32'(busy), 32'd1);
    repeat (3) cyc();
    comp_done = 1'b1; cyc(); comp_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("res_valid_hold", 32'(res_valid), 32'd1);
      chk("res_busy_hold", 32'(busy), 32'd1);
      cyc();
    end
    res_ready = 1'b1;
    chk("res_valid_4th", 32'(res_valid), 32'd1);
    cyc(); res_ready = 1'b0;
    chk("res_valid_cleared", 32'(res_valid), 32'd0);
    chk("busy_cleared", 32'(busy), 32'd0);

    // Job 2: gapped stream, then start+res_ready together in RESULT
    load_beats(17, 2 * NR * NC, 1'b1);
    chk("comp_start_gapped", 32'(comp_start), 32'd1);
    comp_done = 1'b1; cyc(); comp_done = 1'b0;
    start = 1'b1; res_ready = 1'b1;
    chk("res_valid_job2", 32'(res_valid), 32'd1);
    cyc(); start = 1'b0; res_ready = 1'b0;
    chk("start_res_to_idle", 32'(busy), 32'd0);
    cyc();
    chk("no_restart", 32'(busy), 32'd0);
    chk("no_restart_ready", 32'(in_ready), 32'd0);

    // Abort after 5th B beat, with a beat presented in the abort cycle
    load_beats(101, NR * NC + 5, 1'b0);
    in_valid = 1'b1; in_data = W'(99); abort = 1'b1;
    cyc(); abort = 1'b0; in_valid = 1'b0;
    chk("abort_idle", 32'(busy), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    load_beats(33, 2 * NR * NC, 1'b0);
    finish_job();

`ifdef LOAD_TIMEOUT_EN
    load_beats(49, 2 * NR * NC, 1'b0);
    repeat (7) cyc();
    chk("to_still_compute", 32'(busy), 32'd1);
    chk("to_no_error_yet", 32'(error), 32'd0);
    cyc();
    chk("to_idle", 32'(busy), 32'd0);
    chk("to_error", 32'(error), 32'd1);
    cyc();
    chk("to_error_sticky", 32'(error), 32'd1);
    start = 1'b1; cyc(); start = 1'b0;
    chk("to_error_cleared", 32'(error), 32'd0);
    abort = 1'b1; cyc(); abort = 1'b0;
    chk("to_abort_idle", 32'(busy), 32'd0);
`else
    chk("error_tied_low", 32'(error), 32'd0);
`endif

    // Asynchronous reset in the middle of LOAD_A
    load_beats(200, 3, 1'b0);
    in_valid = 1'b1; in_data = W'(77);
    #2 rst = 1'b0;
    #1;
    chk("arst_we", 32'({a_we, b_we}), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd0);
    chk("arst_addr", 32'({wr_row, wr_col}), 32'd0);
    chk("arst_data", 32'(wr_data), 32'd0);
    chk("arst_misc", 32'({comp_start, res_valid, error}), 32'd0);
    @(posedge clk); #1 in_valid = 1'b0; rst = 1'b1;
    cyc();
    chk("arst_recover_idle", 32'(busy), 32'd0);
    load_beats(300, 2 * NR * NC, 1'b0);
    finish_job();

    cyc();
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
